// File: rtl/float_adder_arbiter_if.sv
// Client and adder-side signal bundle for float_adder_arbiter.
// slave = arbiter side, master = requesters/consumer/adder side.
interface float_adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8
);
  // Handshakes: a transfer happens on a rising clock edge where valid & ready are
  // both 1; payload must be stable while valid is 1 and ready is 0. Valid never
  // waits on ready. An accepted request is not remembered if valid drops early.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_y;
  logic                      rsp_timeout;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic                      add_reset;
  logic [DATA_W-1:0]         add_y;
  logic                      add_valid;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_y, add_valid,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_timeout, add_a, add_b, add_reset
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_y, add_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_timeout, add_a, add_b, add_reset
  );
endinterface

// File: rtl/float_adder_arbiter.sv
// Round-robin arbiter sharing one multi-cycle e4m3 adder between NUM_REQ clients.
// Optional WAIT watchdog returning a NaN result: define ADDER_TIMEOUT_EN.
module float_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  float_adder_arbiter_if.slave bus,
  output logic [1:0]           dbg_state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] NAN_Y = {1'b0, {(DATA_W-1){1'b1}}};

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            wait_first;
  logic            timeout_hit;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant       = last_grant;
    grant_found = 1'b0;
    cand        = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (reset && state == IDLE && grant_found) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

`ifdef ADDER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == START) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fires in the WAIT cycle whose completion brings the count to TIMEOUT.
  assign timeout_hit = (state == WAIT) && (wait_cnt + 8'd1 == TIMEOUT_CNT);
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      last_grant      <= ID_W'(NUM_REQ - 1);
      wait_first      <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_y       <= '0;
      bus.rsp_timeout <= 1'b0;
      bus.add_a       <= '0;
      bus.add_b       <= '0;
      bus.add_reset   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            bus.add_a  <= bus.req_a[grant*DATA_W +: DATA_W];
            bus.add_b  <= bus.req_b[grant*DATA_W +: DATA_W];
            bus.rsp_id <= grant;
            last_grant <= grant;
            state      <= START;
          end
        end
        START: begin
          bus.add_reset <= 1'b0;
          wait_first    <= 1'b1;
          state         <= WAIT;
        end
        WAIT: begin
          // The adder's first cycle after release is its EXP step; its flag is not yet meaningful.
          wait_first <= 1'b0;
          if (!wait_first && bus.add_valid) begin
            bus.rsp_y       <= bus.add_y;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (timeout_hit) begin
            bus.rsp_y       <= NAN_Y;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.add_reset <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_float_adder_arbiter.sv
// Directed bench for float_adder_arbiter with a table-driven e4m3 adder model.
module tb_float_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int RW      = ID_W + DATA_W;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  float_adder_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  float_adder_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  int adder_lat  = 2;
  bit adder_hang = 1'b0;
  int adder_cnt  = 0;

  // Hand-computed e4m3 sums (bias 7): 1.0+1.0=2.0, 1.0-1.0=0, 2.0+1.0=3.0.
  function automatic logic [7:0] e4m3_sum(input logic [7:0] a, input logic [7:0] b);
    case ({a, b})
      16'h3838: return 8'h40;
      16'h38B8: return 8'h00;
      16'h4038: return 8'h44;
      default:  return 8'hEE;
    endcase
  endfunction

  // Adder model: restarts while add_reset is high, raises add_valid adder_lat cycles later.
  always @(negedge clock) begin
    if (!reset || bus.add_reset) begin
      adder_cnt     = 0;
      bus.add_valid = 1'b0;
      bus.add_y     = '0;
    end else begin
      adder_cnt++;
      if (!adder_hang && adder_cnt >= adder_lat) begin
        bus.add_valid = 1'b1;
        bus.add_y     = e4m3_sum(bus.add_a, bus.add_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Presents one request for a single cycle; returns at the negedge after the handshake.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input bit push);
    bus.req_valid[id]                = 1'b1;
    bus.req_a[id*DATA_W +: DATA_W]   = a;
    bus.req_b[id*DATA_W +: DATA_W]   = b;
    #1;
    check("req_ready_onehot", bus.req_ready, 32'(1) << id);
    if (push) exp_q.push_back({ID_W'(id), e4m3_sum(a, b)});
    @(negedge clock);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (!bus.rsp_valid && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("rsp_arrives", bus.rsp_valid, 1);
  endtask

  task automatic take_rsp();
    logic [RW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("rsp_id", bus.rsp_id, e[RW-1:DATA_W]);
    check("rsp_y", bus.rsp_y, e[DATA_W-1:0]);
    check("rsp_timeout", bus.rsp_timeout, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int got;
    int seen;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset values, with every requester asking so req_ready gating is visible.
    reset         = 1'b0;
    bus.req_valid = '1;
    repeat (2) @(negedge clock);
    check("rst_state", dbg_state, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_add_a", bus.add_a, 0);
    check("rst_add_b", bus.add_b, 0);
    check("rst_add_reset", bus.add_reset, 1);
    bus.req_valid = '0;
    reset         = 1'b1;
    @(negedge clock);

    // 1.0 + 1.0 from requester 0, with per-stage checks and latency.
    issue(0, 8'h38, 8'h38, 1'b1);
    check("start_state", dbg_state, 1);
    check("start_add_a", bus.add_a, 8'h38);
    check("start_add_b", bus.add_b, 8'h38);
    check("start_add_reset", bus.add_reset, 1);
    cyc = 1;
    @(negedge clock);
    cyc++;
    check("wait_state", dbg_state, 2);
    check("wait_add_reset", bus.add_reset, 0);
    while (!bus.rsp_valid && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("latency", cyc, 4);
    check("resp_state", dbg_state, 3);
    take_rsp();

    // Round robin with all requesters held valid and the consumer always ready.
    apply_reset();
    bus.req_a     = {8'h38, 8'h40, 8'h38, 8'h38};
    bus.req_b     = {8'h38, 8'h38, 8'hB8, 8'h38};
    exp_q.push_back({2'd0, 8'h40});
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h44});
    exp_q.push_back({2'd3, 8'h40});
    exp_q.push_back({2'd0, 8'h40});
    exp_q.push_back({2'd1, 8'h00});
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (bus.rsp_valid) begin
        logic [RW-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("rr_id", bus.rsp_id, e[RW-1:DATA_W]);
        check("rr_y", bus.rsp_y, e[DATA_W-1:0]);
        got++;
        if (got == 6) bus.req_valid = '0;
      end
    end
    check("rr_count", got, 6);
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("rr_idle", dbg_state, 0);

    // 1.0 + -1.0 from requester 1 (last_grant is 1, so it is still reachable).
    issue(1, 8'h38, 8'hB8, 1'b1);
    wait_rsp(50);
    take_rsp();

    // Back-pressure in RESP while another requester waits.
    issue(3, 8'h38, 8'h38, 1'b1);
    wait_rsp(50);
    bus.req_valid[0]            = 1'b1;
    bus.req_a[0 +: DATA_W]      = 8'h40;
    bus.req_b[0 +: DATA_W]      = 8'h38;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_y", bus.rsp_y, 8'h40);
      check("hold_rsp_id", bus.rsp_id, 3);
      check("hold_req_ready", bus.req_ready, 0);
      @(negedge clock);
    end
    take_rsp();
    #1;
    check("after_resp_state", dbg_state, 0);
    check("after_resp_ready", bus.req_ready, 4'b0001);
    exp_q.push_back({2'd0, 8'h44});
    @(negedge clock);
    bus.req_valid[0] = 1'b0;
    check("after_resp_start", dbg_state, 1);
    wait_rsp(50);
    take_rsp();

    // Asynchronous reset while the adder is busy discards the operation.
    issue(0, 8'h38, 8'h38, 1'b0);
    cyc = 0;
    while (dbg_state != 2 && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    check("abort_in_wait", dbg_state, 2);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_add_reset", bus.add_reset, 1);
    check("abort_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b1;
    seen  = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    issue(2, 8'h40, 8'h38, 1'b1);
    wait_rsp(50);
    take_rsp();

    // Adder that never answers.
    adder_hang = 1'b1;
`ifdef ADDER_TIMEOUT_EN
    issue(1, 8'h38, 8'h38, 1'b0);
    seen = 0;
    cyc  = 0;
    while (!bus.rsp_valid && cyc < 50) begin
      if (dbg_state == 2) seen++;
      @(negedge clock);
      cyc++;
    end
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_wait_cycles", seen, TIMEOUT);
    check("to_rsp_y", bus.rsp_y, 8'h7F);
    check("to_rsp_timeout", bus.rsp_timeout, 1);
    check("to_rsp_id", bus.rsp_id, 1);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    adder_hang    = 1'b0;
    check("to_idle", dbg_state, 0);
`else
    issue(1, 8'h38, 8'h38, 1'b1);
    @(negedge clock);
    seen = 0;
    repeat (100) begin
      if (dbg_state != 2 || bus.rsp_valid) seen++;
      @(negedge clock);
    end
    check("hang_stays_wait", seen, 0);
    check("hang_state", dbg_state, 2);
    adder_hang = 1'b0;
    wait_rsp(50);
    take_rsp();
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
